// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Per-register stall vectors: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb [5]=wb
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  // Default redirect target for exceptions.
  localparam logic [31:0] ExcVector = 32'hBFC00380;

  // Divider handshake state.
  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_timeout.sv
// MEM bus-timeout detector: counts consecutive MEM stall cycles and emits a
// one-cycle bus_err pulse on every BUS_TIMEOUT-th cycle of a persisting stall.
module pipe_ctrl_timeout
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stallreq_mem,
  input  logic flush,
  output logic bus_err
);

  localparam int unsigned CntW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Next count and timeout pulse; a flush abandons the pending access.
  always_comb begin
    cnt_d   = '0;
    bus_err = 1'b0;
    if (!rst && stallreq_mem && !flush) begin
      if (cnt_q == CntLast) begin
        bus_err = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests into a per-register
// stall vector, runs the divider handshake, issues flush/redirect on
// exception or ERET, and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = ExcVector,
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_mem,
  input  logic             div_req,
  input  logic             div_ready,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic             div_start,
  output logic             div_cancel,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Flush/redirect, stall priority mux and divider FSM next state.
  always_comb begin
    state_d    = state_q;
    stall      = StallNone;
    flush      = 1'b0;
    flush_pc   = '0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    if (!rst) begin
      flush = exc_valid | eret_valid;
      if (exc_valid) begin
        flush_pc = EXC_VECTOR;
      end else if (eret_valid) begin
        flush_pc = cp0_epc;
      end
      unique case (state_q)
        RUN: begin
          if (flush) begin
            stall = StallNone;
          end else if (stallreq_mem) begin
            stall = StallMem;
          end else if (div_req) begin
            div_start = 1'b1;
            stall     = StallEx;
            state_d   = DIV_WAIT;
          end else if (stallreq_id) begin
            stall = StallId;
          end
        end
        DIV_WAIT: begin
          if (flush) begin
            div_cancel = 1'b1;
            state_d    = RUN;
          end else begin
            // Once the result arrives the EX hold is released in the same
            // cycle, so a pending ID request falls through to its own vector.
            if (div_ready) begin
              state_d = RUN;
            end
            if (stallreq_mem) begin
              stall = StallMem;
            end else if (!div_ready) begin
              stall = StallEx;
            end else if (stallreq_id) begin
              stall = StallId;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Performance counter next value: count every cycle the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0]) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  pipe_ctrl_timeout #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_timeout (
    .clk         (clk),
    .rst         (rst),
    .stallreq_mem(stallreq_mem),
    .flush       (flush),
    .bus_err     (bus_err)
  );

endmodule
